// File: rtl/ghr_hash_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ghr_hash_queue                                                  |
// | Brief    : Speculative GHR + PC hash for choice-table lookup, with an      |
// |            in-flight branch queue that replays hashes at resolution.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ghr_hash_queue #(
    parameter int ch_width = 14,
    parameter int q_depth  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                pdc_valid,
    input  logic                pdc_taken,
    output logic [ch_width-1:0] hashed_pc,
    output logic                q_full,
    input  logic                ex_valid,
    input  logic                ex_mispredict,
    input  logic                ex_taken,
    output logic [ch_width-1:0] hashed_pc_update,
    output logic                update_en,
    output logic [ch_width-1:0] ghr_spec
);

    localparam int                 c_PTR_W   = $clog2(q_depth);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W+1)'(q_depth);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [ch_width-1:0] r_ghr;
    logic [ch_width-1:0] r_hpu;
    logic                r_upd_en;
    logic [c_PTR_W:0]    r_count;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_PTR_W-1:0]  r_wptr;
    logic [ch_width-1:0] r_hash_mem [q_depth];
    logic [ch_width-1:0] r_ghr_mem  [q_depth];

    logic                w_empty;
    logic                w_pop;
    logic                w_flush;
    logic                w_push;
    logic [ch_width-1:0] w_head_hash;
    logic [ch_width-1:0] w_head_ghr;
    logic                w_unused_bits;

    assign hashed_pc        = pc[ch_width+1:2] ^ r_ghr;
    assign q_full           = (r_count == c_DEPTH);
    assign ghr_spec         = r_ghr;
    assign hashed_pc_update = r_hpu;
    assign update_en        = r_upd_en;

    assign w_empty     = (r_count == '0);
    assign w_head_hash = r_hash_mem[r_rptr];
    assign w_head_ghr  = r_ghr_mem[r_rptr];
    assign w_pop       = ex_valid & ~w_empty;
    assign w_flush     = w_pop & ex_mispredict;
    // A pop frees the head slot this cycle, so a full queue can still accept
    // a push alongside a non-mispredict pop.
    assign w_push      = pdc_valid & (~q_full | w_pop) & ~w_flush;

    assign w_unused_bits = ^{pc[31:ch_width+2], pc[1:0], w_head_ghr[ch_width-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr    <= '0;
            r_hpu    <= '0;
            r_upd_en <= 1'b0;
            r_count  <= '0;
            r_rptr   <= '0;
            r_wptr   <= '0;
        end else begin
            r_upd_en <= w_pop;
            if (w_pop) begin
                r_hpu <= w_head_hash;
            end

            if (w_flush) begin
                r_ghr   <= {w_head_ghr[ch_width-2:0], ex_taken};
                r_count <= '0;
                r_rptr  <= r_rptr + c_PTR_ONE;
                r_wptr  <= r_rptr + c_PTR_ONE;
            end else begin
                if (w_push) begin
                    r_ghr  <= {r_ghr[ch_width-2:0], pdc_taken};
                    r_wptr <= r_wptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

    // Entry storage is never reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_hash_mem[r_wptr] <= hashed_pc;
            r_ghr_mem[r_wptr]  <= r_ghr;
        end
    end

endmodule
`default_nettype wire
